encoder_sample_ctrl: RTL and testbench

- Controller for the 32-bit quadrature position counter. It sequences sampling and homing of the counter and owns the counter's reset line.
- Samples the counter at a fixed programmable rate and computes a per-period velocity (delta count).
- Presents each position/velocity pair to the DSP control loop over a valid/ready handshake.
- Runs an index-pulse homing sequence that zeroes the counter.

---
 rtl/encoder_sample_ctrl_if.sv | 40 ++++
 rtl/encoder_sample_ctrl.sv | 217 +++++++++++++++++++++
 tb/tb_encoder_sample_ctrl.sv | 314 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/encoder_sample_ctrl_if.sv
// ---------------------------------------------------------------------------
// encoder_sample_ctrl_if
//   Sample delivery channel from the encoder sampling controller to the DSP
//   control loop.
//
//   Handshake: the producer raises sample_valid when pos_out/vel_out hold a
//   sample. A transfer happens on any rising clk edge where sample_valid and
//   sample_ready are both high. While sample_valid is high and sample_ready
//   is low, pos_out/vel_out are held, except when the producer overwrites
//   them with a newer sample and flags an overrun. The consumer may drive
//   sample_ready at any time, without waiting for sample_valid.
//
//   Signals:
//     sample_valid  producer -> consumer  pos_out/vel_out hold an unaccepted sample
//     sample_ready  consumer -> producer  consumer accepts the sample this cycle
//     pos_out[31:0] producer -> consumer  latched position count
//     vel_out[31:0] producer -> consumer  signed delta count over the last period
//
//   Modports: master = sample producer (the controller), slave = consumer.
// ---------------------------------------------------------------------------
interface encoder_sample_ctrl_if;
   logic        sample_valid;
   logic        sample_ready;
   logic [31:0] pos_out;
   logic [31:0] vel_out;

   modport master (
      output sample_valid,
      output pos_out,
      output vel_out,
      input  sample_ready
   );

   modport slave (
      input  sample_valid,
      input  pos_out,
      input  vel_out,
      output sample_ready
   );
endinterface

// File: rtl/encoder_sample_ctrl.sv
// ---------------------------------------------------------------------------
// encoder_sample_ctrl
//   Sequences sampling and homing of a 32-bit quadrature position counter.
//   In RUN the counter is sampled once every SAMPLE_DIV clk cycles; each
//   sample carries the position and the delta since the previous sample.
//   A homing request waits (bounded by HOME_TIMEOUT cycles) for a rising
//   edge on the encoder index pulse, then pulses the decoder reset for one
//   cycle and restarts sampling from a zero reference.
//
//   Ports:
//     clk          in   system clock
//     rst          in   asynchronous, active-high reset
//     count_in     in   position count from the quadrature decoder (clk domain)
//     index_in     in   encoder index pulse, asynchronous to clk
//     home_req     in   single-cycle request to start homing
//     clr_ovr      in   single-cycle clear of the overrun flag
//     smp          if   sample channel (master side): sample_valid, pos_out,
//                       vel_out out; sample_ready in
//     dec_rst      out  registered reset to the quadrature decoder
//     homed        out  homing completed successfully
//     home_err     out  sticky: last homing attempt timed out
//     overrun      out  sticky: a sample was overwritten before acceptance
//     busy         out  a homing sequence is in progress
//     dbg_state_o  out  current FSM state encoding (observation only)
// ---------------------------------------------------------------------------
module encoder_sample_ctrl #(
   parameter int unsigned SAMPLE_DIV   = 1000,    // clk cycles per sample period, >= 4
   parameter int unsigned HOME_TIMEOUT = 1000000  // max cycles waiting for index, >= 2
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [31:0]           count_in,
   input  logic                  index_in,
   input  logic                  home_req,
   input  logic                  clr_ovr,
   encoder_sample_ctrl_if.master smp,
   output logic                  dec_rst,
   output logic                  homed,
   output logic                  home_err,
   output logic                  overrun,
   output logic                  busy,
   output logic [1:0]            dbg_state_o
);

   localparam int unsigned DIV_W = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
   localparam int unsigned TO_W  = (HOME_TIMEOUT > 1) ? $clog2(HOME_TIMEOUT) : 1;
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SAMPLE_DIV - 1);
   localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(HOME_TIMEOUT - 1);

   typedef enum logic [1:0] {
      ST_RUN         = 2'd0,
      ST_HOME_WAIT   = 2'd1,
      ST_HOME_CLR    = 2'd2,
      ST_HOME_SETTLE = 2'd3
   } state_t;

   state_t           state_q, state_d;
   logic [DIV_W-1:0] div_q, div_d;
   logic [TO_W-1:0]  tout_q, tout_d;
   logic [31:0]      prev_q, prev_d;
   logic [31:0]      pos_q, pos_d;
   logic [31:0]      vel_q, vel_d;
   logic             valid_q, valid_d;
   logic             ovr_q, ovr_d;
   logic             homed_q, homed_d;
   logic             err_q, err_d;
   logic             dec_rst_q, dec_rst_d;

   // Index synchronizer: two flops for metastability plus one delay flop
   // so a rising edge can be detected as a single-cycle pulse.
   logic idx_s1_q, idx_s2_q, idx_s3_q;

   logic tick;        // last cycle of a sample period
   logic idx_edge;    // synchronized rising edge of index_in
   logic accept;      // current sample is taken by the consumer this cycle
   logic enter_wait;  // leaving RUN for HOME_WAIT this cycle
   logic ovr_set;     // a pending sample is being overwritten this cycle

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         idx_s1_q <= 1'b0;
         idx_s2_q <= 1'b0;
         idx_s3_q <= 1'b0;
      end else begin
         idx_s1_q <= index_in;
         idx_s2_q <= idx_s1_q;
         idx_s3_q <= idx_s2_q;
      end
   end

   assign idx_edge = idx_s2_q & ~idx_s3_q;
   assign tick     = (state_q == ST_RUN) && (div_q == DIV_LAST);
   assign accept   = valid_q & smp.sample_ready;

   // State register and all datapath registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= ST_RUN;
         div_q     <= '0;
         tout_q    <= '0;
         prev_q    <= '0;
         pos_q     <= '0;
         vel_q     <= '0;
         valid_q   <= 1'b0;
         ovr_q     <= 1'b0;
         homed_q   <= 1'b0;
         err_q     <= 1'b0;
         dec_rst_q <= 1'b1;
      end else begin
         state_q   <= state_d;
         div_q     <= div_d;
         tout_q    <= tout_d;
         prev_q    <= prev_d;
         pos_q     <= pos_d;
         vel_q     <= vel_d;
         valid_q   <= valid_d;
         ovr_q     <= ovr_d;
         homed_q   <= homed_d;
         err_q     <= err_d;
         dec_rst_q <= dec_rst_d;
      end
   end

   // Next-state and datapath logic.
   always_comb begin
      state_d    = state_q;
      div_d      = div_q;
      tout_d     = tout_q;
      prev_d     = prev_q;
      pos_d      = pos_q;
      vel_d      = vel_q;
      valid_d    = valid_q;
      homed_d    = homed_q;
      err_d      = err_q;
      enter_wait = 1'b0;
      ovr_set    = 1'b0;

      // Sampling and handshake. A tick always loads a new sample; if the
      // old one is still pending and not being taken, it is lost (overrun).
      // If it is being taken on the same edge, valid simply stays high.
      if (tick) begin
         pos_d   = count_in;
         vel_d   = count_in - prev_q;  // modulo 2^32 gives the signed delta
         prev_d  = count_in;
         valid_d = 1'b1;
         ovr_set = valid_q & ~smp.sample_ready;
      end else if (accept) begin
         valid_d = 1'b0;
      end

      case (state_q)
         ST_RUN: begin
            div_d = tick ? '0 : div_q + 1'b1;
            // A coincident tick has already been sampled above.
            if (home_req) begin
               state_d    = ST_HOME_WAIT;
               enter_wait = 1'b1;
               div_d      = '0;
               tout_d     = '0;
               homed_d    = 1'b0;
               err_d      = 1'b0;
            end
         end
         ST_HOME_WAIT: begin
            div_d = '0;
            // An index edge wins over a timeout in the same cycle. On timeout
            // the counter is left at its final value.
            if (idx_edge) begin
               state_d = ST_HOME_CLR;
            end else if (tout_q == TO_LAST) begin
               err_d   = 1'b1;
               state_d = ST_RUN;
            end else begin
               tout_d = tout_q + 1'b1;
            end
         end
         ST_HOME_CLR: begin
            div_d   = '0;
            state_d = ST_HOME_SETTLE;
         end
         ST_HOME_SETTLE: begin
            // The decoder was cleared on the previous edge, so the next delta
            // is measured from zero and a full period elapses before it.
            div_d   = '0;
            prev_d  = '0;
            homed_d = 1'b1;
            state_d = ST_RUN;
         end
         default: begin
            state_d = ST_RUN;
         end
      endcase

      // A new overrun event takes priority over any clear.
      if (ovr_set) begin
         ovr_d = 1'b1;
      end else if (clr_ovr || enter_wait) begin
         ovr_d = 1'b0;
      end else begin
         ovr_d = ovr_q;
      end

      // Registered so dec_rst is high for exactly the cycle spent in HOME_CLR.
      dec_rst_d = (state_d == ST_HOME_CLR);
   end

   assign smp.sample_valid = valid_q;
   assign smp.pos_out      = pos_q;
   assign smp.vel_out      = vel_q;
   assign dec_rst          = dec_rst_q;
   assign homed            = homed_q;
   assign home_err         = err_q;
   assign overrun          = ovr_q;
   assign busy             = (state_q != ST_RUN);
   assign dbg_state_o      = state_q;

endmodule

// File: tb/tb_encoder_sample_ctrl.sv
// ---------------------------------------------------------------------------
// tb_encoder_sample_ctrl
//   Directed phases following the controller's intended use, then a
//   randomized phase. A behavioural model predicts every sample and the flag
//   outputs; samples go into an expected queue that a monitor drains on each
//   transfer. Inputs change 1ns after the rising edge; the monitor looks at
//   the DUT on the falling edge.
// ---------------------------------------------------------------------------
module tb_encoder_sample_ctrl;
   localparam int SD = 10;
   localparam int HT = 50;

   // ---------------- clock / reset / DUT ----------------
   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] count_in;
   logic        index_in;
   logic        home_req;
   logic        clr_ovr;
   logic        dec_rst;
   logic        homed;
   logic        home_err;
   logic        overrun;
   logic        busy;
   logic [1:0]  dbg_state;

   encoder_sample_ctrl_if smp();

   encoder_sample_ctrl #(.SAMPLE_DIV(SD), .HOME_TIMEOUT(HT)) dut (
      .clk        (clk),
      .rst        (rst),
      .count_in   (count_in),
      .index_in   (index_in),
      .home_req   (home_req),
      .clr_ovr    (clr_ovr),
      .smp        (smp.master),
      .dec_rst    (dec_rst),
      .homed      (homed),
      .home_err   (home_err),
      .overrun    (overrun),
      .busy       (busy),
      .dbg_state_o(dbg_state)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // ---------------- quadrature decoder stand-in ----------------
   // Clears on an edge where dec_rst is high, otherwise loads or ramps.
   logic        dec_seen = 1'b1;
   logic        load_en  = 1'b0;
   logic [31:0] load_val = '0;
   logic [31:0] step     = '0;

   initial begin
      count_in = '0;
      forever begin
         @(negedge clk);
         dec_seen = dec_rst;
         @(posedge clk);
         #1;
         if (dec_seen) count_in = '0;
         else if (load_en) begin
            count_in = load_val;
            load_en  = 1'b0;
         end else count_in = count_in + step;
      end
   end

   // ---------------- reference model ----------------
   // mode: 0 sampling, 1 waiting for index, 2 decoder clear, 3 settle
   logic [63:0] exp_q[$];
   int          m_mode   = 0;
   int          m_run    = 0;   // cycles into the current sample period
   int          m_wait   = 0;   // cycles spent waiting for the index
   logic [2:0]  m_idx    = '0;  // index_in as seen 1, 2 and 3 edges ago
   logic [31:0] m_prev   = '0;
   logic        m_valid  = 1'b0;
   logic        m_ovr    = 1'b0;
   logic        m_homed  = 1'b0;
   logic        m_err    = 1'b0;
   logic        m_dec    = 1'b1;

   initial begin
      forever begin
         @(posedge clk or posedge rst);
         if (rst) begin
            exp_q.delete();
            m_mode = 0; m_run = 0; m_wait = 0; m_idx = '0; m_prev = '0;
            m_valid = 1'b0; m_ovr = 1'b0; m_homed = 1'b0; m_err = 1'b0; m_dec = 1'b1;
         end else begin
            logic due, ov, enter, rise;
            rise  = m_idx[1] & ~m_idx[2];
            m_idx = {m_idx[1:0], index_in};
            due   = (m_mode == 0) && (m_run == SD - 1);
            ov    = 1'b0;
            enter = 1'b0;
            if (due) begin
               if (m_valid && !smp.sample_ready) begin
                  void'(exp_q.pop_back());
                  ov = 1'b1;
               end
               exp_q.push_back({count_in, count_in - m_prev});
               m_prev  = count_in;
               m_valid = 1'b1;
            end else if (m_valid && smp.sample_ready) begin
               m_valid = 1'b0;
            end
            case (m_mode)
               0: begin
                  m_run = due ? 0 : m_run + 1;
                  if (home_req) begin
                     m_mode = 1; enter = 1'b1; m_run = 0; m_wait = 0;
                     m_homed = 1'b0; m_err = 1'b0;
                  end
               end
               1: begin
                  if (rise) m_mode = 2;
                  else if (m_wait == HT - 1) begin
                     m_err = 1'b1; m_mode = 0;
                  end else m_wait++;
               end
               2: m_mode = 3;
               default: begin
                  m_prev = '0; m_run = 0; m_homed = 1'b1; m_mode = 0;
               end
            endcase
            if (ov) m_ovr = 1'b1;
            else if (clr_ovr || enter) m_ovr = 1'b0;
            m_dec = (m_mode == 2);
         end
      end
   end

   // ---------------- monitor / scoreboard ----------------
   initial begin
      forever begin
         @(negedge clk);
         chk("flags{valid,ovr,homed,err,busy,dec_rst}",
             {58'd0, smp.sample_valid, overrun, homed, home_err, busy, dec_rst},
             {58'd0, m_valid, m_ovr, m_homed, m_err, (m_mode != 0), m_dec});
         if (smp.sample_valid && smp.sample_ready) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL transfer: got pos=%0h with no sample expected", smp.pos_out);
            end else begin
               logic [63:0] e;
               e = exp_q.pop_front();
               chk("pos_out", {32'd0, smp.pos_out}, {32'd0, e[63:32]});
               chk("vel_out", {32'd0, smp.vel_out}, {32'd0, e[31:0]});
            end
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic cyc(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Edges until sample_valid is seen high (bounded).
   task automatic wait_valid(output int n);
      n = 0;
      do begin
         cyc(1);
         n++;
      end while (!smp.sample_valid && n < 4 * SD);
   endtask

   task automatic wait_flag(input int which, input int limit, output int n);
      logic f;
      n = 0;
      do begin
         cyc(1);
         n++;
         f = (which == 0) ? dec_rst : home_err;
      end while (!f && n < limit);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   // ---------------- stimulus ----------------
   initial begin
      int n;
      rst = 1'b1; index_in = 1'b0; home_req = 1'b0; clr_ovr = 1'b0;
      smp.sample_ready = 1'b1;
      load_val = 32'd100; load_en = 1'b1; step = '0;
      cyc(3);

      // Reset state
      chk("rst_dec_rst",  {63'd0, dec_rst}, 64'd1);
      chk("rst_outputs",  {58'd0, smp.sample_valid, homed, home_err, overrun, busy, 1'b0}, 64'd0);
      chk("rst_pos_vel",  {smp.pos_out, smp.vel_out}, 64'd0);
      chk("rst_state",    {62'd0, dbg_state}, 64'd0);

      // 1: constant count, first sample after 10 edges
      rst = 1'b0;
      wait_valid(n);
      chk("first_sample_latency", n, SD);
      chk("first_pos", {32'd0, smp.pos_out}, 64'd100);
      chk("first_vel", {32'd0, smp.vel_out}, 64'd100);
      wait_valid(n);
      chk("sample_period", n, SD);
      chk("const_vel", {32'd0, smp.vel_out}, 64'd0);

      // 2: ramps up and down through zero
      step = 32'd3;
      repeat (3) wait_valid(n);
      chk("ramp_up_vel", {32'd0, smp.vel_out}, 64'h1E);
      load_val = 32'd20; load_en = 1'b1; step = 32'hFFFF_FFFD;
      wait_valid(n);
      chk("ramp_down_pos_wrap", {36'd0, smp.pos_out[31:4]}, 64'h0FFF_FFFF);
      repeat (2) wait_valid(n);
      chk("ramp_down_vel", {32'd0, smp.vel_out}, 64'hFFFF_FFE2);

      // 3: backpressure, overrun, clear, tick together with ready
      smp.sample_ready = 1'b0;
      cyc(25);
      chk("overrun_set", {63'd0, overrun}, 64'd1);
      smp.sample_ready = 1'b1;
      cyc(1);
      chk("accept_clears_valid", {63'd0, smp.sample_valid}, 64'd0);
      clr_ovr = 1'b1;
      cyc(1);
      clr_ovr = 1'b0;
      chk("clr_ovr", {63'd0, overrun}, 64'd0);
      smp.sample_ready = 1'b0;
      cyc(12);
      smp.sample_ready = 1'b1;
      cyc(1);
      chk("tick_ready_valid", {63'd0, smp.sample_valid}, 64'd1);
      chk("tick_ready_no_ovr", {63'd0, overrun}, 64'd0);

      // 4: homing with an index pulse
      step = 32'($urandom_range(1, 7));
      home_req = 1'b1;
      cyc(1);
      home_req = 1'b0;
      chk("home_busy", {63'd0, busy}, 64'd1);
      chk("home_state", {62'd0, dbg_state}, 64'd1);
      cyc(4);
      index_in = 1'b1;
      wait_flag(0, 10, n);
      chk("dec_rst_latency", n, 3);
      cyc(1);
      chk("dec_rst_single", {63'd0, dec_rst}, 64'd0);
      cyc(1);
      chk("homed_set", {63'd0, homed}, 64'd1);
      chk("home_done_busy", {63'd0, busy}, 64'd0);
      index_in = 1'b0;
      wait_valid(n);
      chk("post_home_latency", n, SD);

      // 5: homing timeout
      home_req = 1'b1;
      cyc(1);
      home_req = 1'b0;
      wait_flag(1, 3 * HT, n);
      chk("timeout_cycles", n, HT);
      chk("timeout_homed", {63'd0, homed}, 64'd0);
      chk("timeout_busy", {63'd0, busy}, 64'd0);
      wait_valid(n);
      chk("post_timeout_latency", n, SD);

      // 6: reset during HOME_WAIT
      home_req = 1'b1;
      cyc(1);
      home_req = 1'b0;
      cyc(3);
      rst = 1'b1;
      #1;
      chk("midrst_dec_rst", {63'd0, dec_rst}, 64'd1);
      chk("midrst_outputs", {58'd0, smp.sample_valid, homed, home_err, overrun, busy, 1'b0}, 64'd0);
      chk("midrst_pos_vel", {smp.pos_out, smp.vel_out}, 64'd0);
      cyc(2);
      rst = 1'b0;
      wait_valid(n);
      chk("post_rst_latency", n, SD);

      // Randomized traffic
      for (int c = 0; c < 1500; c++) begin
         smp.sample_ready = ($urandom_range(0, 9) < 7);
         clr_ovr  = ($urandom_range(0, 19) == 0);
         home_req = ($urandom_range(0, 149) == 0);
         if (home_req) smp.sample_ready = 1'b1;
         if ($urandom_range(0, 29) == 0) index_in = ~index_in;
         if ($urandom_range(0, 99) == 0) step = $urandom;
         cyc(1);
      end
      home_req = 1'b0; clr_ovr = 1'b0;
      cyc(3);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
